// File: rtl/aes256_key_expander.sv
// AES-256 key schedule, one expanded word per clock.
// Holds all 60 schedule words and serves a 128-bit round key by index.
module aes256_key_expander #(
  parameter int NR     = 14,
  parameter int NWORDS = 4 * (NR + 1)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   enc_keyAddr,
  output logic [127:0] enc_key
);

  typedef enum logic [1:0] {IDLE, EXPAND, VALID} state_t;

  // AES S-box; entry 0 is the most significant byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [5:0] LAST_W = 6'(NWORDS - 1);
  localparam logic [3:0] LAST_A = 4'(NR);

  state_t                   state_q, state_d;
  logic [5:0]               i_q, i_d;
  logic [7:0]               rcon_q, rcon_d;
  logic                     done_q, done_d;
  logic [NWORDS-1:0][31:0]  w_q, w_d;
  logic [31:0]              temp;
  logic [5:0]               rd_base;
  logic                     key_fire;

  assign key_ready  = (state_q != EXPAND);
  assign busy       = (state_q == EXPAND);
  assign keys_valid = (state_q == VALID);
  assign done       = done_q;
  assign key_fire   = key_valid & key_ready;
  assign rd_base    = {enc_keyAddr, 2'b00};

  // State, counter, rcon and schedule registers; reset wipes the key material.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      i_q     <= '0;
      rcon_q  <= '0;
      done_q  <= 1'b0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
      w_q     <= w_d;
    end
  end

  // Next state: load the key in IDLE/VALID, derive one word per cycle in EXPAND.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    rcon_d  = rcon_q;
    w_d     = w_q;
    temp    = '0;
    // done is high only in the first VALID cycle, even if a new key lands then.
    done_d  = (state_q == EXPAND) && (i_q == LAST_W);
    case (state_q)
      IDLE, VALID: begin
        if (key_fire) begin
          for (int k = 0; k < 8; k++) w_d[k] = key_in[32*k +: 32];
          i_d     = 6'd8;
          rcon_d  = 8'h01;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        temp = w_q[i_q - 6'd1];
        if (i_q[2:0] == 3'd0) begin
          // RotWord brings byte 0 to the top, rcon lands in byte 0.
          temp   = sub_word({temp[7:0], temp[31:8]}) ^ {24'h0, rcon_q};
          rcon_d = xtime(rcon_q);
        end else if (i_q[2:0] == 3'd4) begin
          temp = sub_word(temp);
        end
        w_d[i_q] = w_q[i_q - 6'd8] ^ temp;
        i_d      = i_q + 6'd1;
        if (i_q == LAST_W) state_d = VALID;
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational round-key read from registered words; index 15 reads as zero.
  always_comb begin
    enc_key = '0;
    if (enc_keyAddr <= LAST_A)
      enc_key = {w_q[rd_base + 6'd3], w_q[rd_base + 6'd2],
                 w_q[rd_base + 6'd1], w_q[rd_base]};
  end

endmodule

// File: tb/tb_aes256_key_expander.sv
// Bench for aes256_key_expander: GF(2^8)-derived key schedule model,
// per-cycle compare of all outputs, plus FIPS-197 literal pins.
module tb_aes256_key_expander;

  typedef logic [59:0][31:0] ks_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [255:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic [3:0]   enc_keyAddr = 4'd0;
  logic         key_ready, busy, done, keys_valid;
  logic [127:0] enc_key;

  int errors = 0;
  int checks = 0;

  // model state: key accepted at edge e_acc, words visible depend on edges since
  ks_t newk = '0;
  ks_t oldw = '0;
  int  n = 0;
  int  e_acc = 0;
  bit  has_key = 1'b0;
  bit  started = 1'b0;

  aes256_key_expander dut (
    .clk(clk), .resetn(resetn), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .busy(busy), .done(done), .keys_valid(keys_valid),
    .enc_keyAddr(enc_keyAddr), .enc_key(enc_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then affine map
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] y, base;
    y = 8'h01;
    base = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) y = gmul(y, base);
      base = gmul(base, base);
    end
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction

  function automatic ks_t expand(input logic [255:0] k);
    ks_t w;
    logic [31:0] t;
    logic [7:0] rc;
    w = '0;
    rc = 8'h01;
    for (int j = 0; j < 8; j++) w[j] = k[32*j +: 32];
    for (int j = 8; j < 60; j++) begin
      t = w[j-1];
      if (j % 8 == 0) begin
        t = subw({t[7:0], t[31:8]}) ^ {24'h0, rc};
        rc = xt(rc);
      end else if (j % 8 == 4) begin
        t = subw(t);
      end
      w[j] = w[j-8] ^ t;
    end
    return w;
  endfunction

  // word j as seen d edges after acceptance (word j>=8 lands at edge j-7)
  function automatic logic [31:0] vw(input int j, input int d);
    if (has_key && (j < 8 || j - 7 <= d)) return newk[j];
    return oldw[j];
  endfunction

  always @(posedge clk) begin : model
    ks_t snap;
    int dp;
    n = n + 1;
    dp = n - 1 - e_acc;
    if (!resetn) begin
      has_key = 1'b0;
      oldw = '0;
      started = 1'b1;
    end else if (key_valid && (!has_key || dp >= 52)) begin
      for (int j = 0; j < 60; j++) snap[j] = vw(j, dp);
      oldw = snap;
      newk = expand(key_in);
      e_acc = n;
      has_key = 1'b1;
    end
  end

  always @(negedge clk) begin : cmp
    int d, a;
    logic [127:0] ek;
    if (started) begin
      d = n - e_acc;
      chk1("busy", busy, has_key && d < 52);
      chk1("key_ready", key_ready, !(has_key && d < 52));
      chk1("done", done, has_key && d == 52);
      chk1("keys_valid", keys_valid, has_key && d >= 52);
      a = int'(enc_keyAddr);
      ek = '0;
      if (a != 15) ek = {vw(4*a+3, d), vw(4*a+2, d), vw(4*a+1, d), vw(4*a, d)};
      chk("enc_key", enc_key, ek);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    enc_keyAddr = 4'($urandom_range(0, 15));
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [127:0] exp, input string nm);
    enc_keyAddr = a;
    #1;
    chk(nm, enc_key, exp);
  endtask

  function automatic logic [255:0] rnd_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 200);
    chk1("done_seen", done, 1'b1);
  endtask

  // AES-256 encryption of the FIPS plaintext using the served round keys
  task automatic aes_chk();
    logic [7:0] s[16];
    logic [7:0] t[16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] rk, ct;
    for (int i = 0; i < 16; i++) s[i] = 8'(i * 17);
    for (int r = 0; r < 15; r++) begin
      enc_keyAddr = 4'(r);
      #1;
      rk = enc_key;
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sb(s[i]);
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) t[rr + 4*c] = s[rr + 4*((c + rr) % 4)];
        s = t;
        if (r < 14) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[8*i +: 8];
    end
    for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
    chk("aes_ciphertext", ct, 128'h8ea2b7ca516745bfeafc49904b496089);
  endtask

  initial begin : main
    int cyc, rst_at, mode;
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    chk1("reset_key_ready", key_ready, 1'b1);
    chk1("reset_keys_valid", keys_valid, 1'b0);

    // FIPS-197 C.3 key, with an ignored key_valid mid-expansion
    for (int i = 0; i < 32; i++) key_in[8*i +: 8] = 8'(i);
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
      key_valid = (cyc == 10);
      if (cyc == 10) key_in = rnd_key();
    end while (!done && cyc < 200);
    key_valid = 1'b0;
    chk("latency", 128'(cyc), 128'd52);
    read_chk(4'd0, 128'h0f0e0d0c0b0a09080706050403020100, "t1_addr0");
    read_chk(4'd1, 128'h1f1e1d1c1b1a19181716151413121110, "t1_addr1");
    read_chk(4'd2, 128'h9cc072a593ce7fa998c476a19fc273a5, "t1_addr2");
    read_chk(4'd14, 128'h36de686d3cc21a37e97909bfcc79fc24, "t1_addr14");
    read_chk(4'd15, 128'h0, "addr15_zero");
    aes_chk();

    // all-zero key loaded from VALID
    key_in = '0;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk1("t5_kv_drop", keys_valid, 1'b0);
    wait_done(cyc);
    read_chk(4'd2, 128'h63636362636363626363636263636362, "t5_addr2");

    // reset in the middle of an expansion
    key_in = rnd_key();
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (20) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk1("t4_busy", busy, 1'b0);
    chk1("t4_ready", key_ready, 1'b1);
    for (int a = 0; a < 16; a++) read_chk(4'(a), 128'h0, "t4_cleared");
    for (int c = 0; c < 60; c++) begin
      tick();
      chk1("t4_no_done", done, 1'b0);
    end

    // random keys: idle gaps, back-to-back loads on done, stray key_valid, resets
    for (int it = 0; it < 8; it++) begin
      mode = $urandom_range(0, 1);
      if (mode != 0) repeat ($urandom_range(0, 4)) tick();
      key_in = rnd_key();
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      rst_at = (it == 2 || it == 5) ? $urandom_range(1, 50) : 0;
      cyc = 0;
      do begin
        tick();
        cyc++;
        resetn = !(cyc == rst_at);
        if (done) break;
        key_valid = (rst_at == 0) && ($urandom_range(0, 5) == 0);
        if (key_valid) key_in = rnd_key();
      end while (cyc < 60);
      resetn = 1'b1;
      key_valid = 1'b0;
      if (rst_at == 0) chk1("rnd_done", done, 1'b1);
    end
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
